// File: rtl/ecc_pkg.sv
// ecc_pkg: shared SECDED definitions for the ECC encoder and decoder paths
//   ECC_DATA_W / ECC_PARITY_W / ECC_CW_W : payload, Hamming check and codeword widths
//   ECC_LAST_POS                         : highest Hamming position covered by the syndrome
//   PARITY_POS                           : Hamming positions that hold check bits
//   data_pos()                           : data bit index -> Hamming position (1-based)
//   ecc_status_e                         : per-word decode classification
package ecc_pkg;

    localparam int ECC_DATA_W   = 32;
    localparam int ECC_PARITY_W = 6;
    localparam int ECC_CW_W     = ECC_DATA_W + ECC_PARITY_W + 1;
    localparam int ECC_LAST_POS = ECC_CW_W - 1;

    localparam int unsigned PARITY_POS [ECC_PARITY_W] = '{1, 2, 4, 8, 16, 32};

    typedef enum logic [1:0] {
        ECC_CLEAN,
        ECC_SEC,
        ECC_DED
    } ecc_status_e;

    // Data bits occupy the non-check positions in ascending order.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned n;
        int unsigned pos;
        logic        chk;
        n   = 0;
        pos = 0;
        for (int unsigned p = 1; p <= ECC_LAST_POS; p++) begin
            chk = 1'b0;
            for (int k = 0; k < ECC_PARITY_W; k++)
                if (PARITY_POS[k] == p) chk = 1'b1;
            if (!chk) begin
                if (n == idx) pos = p;
                n++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/syndrome_calculator.sv
// syndrome_calculator: combinational Hamming syndrome and overall parity of a codeword
//   i_codeword   : codeword, bit[p-1] = Hamming position p, bit[38] = overall parity
//   o_syndrome   : XOR of the positions of all set bits in positions 1..38
//   o_parity_err : overall even-parity mismatch across the whole codeword
module syndrome_calculator
    import ecc_pkg::*;
(
    input  logic [ECC_CW_W-1:0]     i_codeword,
    output logic [ECC_PARITY_W-1:0] o_syndrome,
    output logic                    o_parity_err
);

    // XOR-ing each set bit's position is the same as computing every check equation at once.
    always_comb begin
        o_syndrome = '0;
        for (int p = 1; p <= ECC_LAST_POS; p++)
            if (i_codeword[p-1]) o_syndrome = o_syndrome ^ ECC_PARITY_W'(p);
    end

    assign o_parity_err = ^i_codeword;

endmodule

// File: rtl/ecc_decoding.sv
// ecc_decoding: 2-stage SECDED read-side decoder (single correct, double detect)
//   ecc_dec_clk / ecc_dec_rstn / ecc_dec_sw_rst : clock, async active-low reset, sync soft reset
//   ecc_en                    : 1 correct/detect, 0 raw pass-through with flags forced low
//   rd_valid_i/rd_addr_i/encoded_data_i : incoming codeword and its address
//   rd_valid_o/rd_addr_o/data_out       : decoded word, two cycles after input
//   single_err_o/double_err_o/syndrome_o: per-word status, zero when rd_valid_o is low
//   err_addr_o                : sticky address of the last flagged word
//   cnt_clr_i                 : clears err_addr_o and the error counters
//   sec_cnt_o/ded_cnt_o       : saturating error counters, present only with ECC_DEC_ERR_CNT_EN
module ecc_decoding
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH        = ECC_DATA_W,
    parameter int MEMORY_DATA_WIDTH = ECC_CW_W,
    parameter int ADDR_WIDTH        = 32,
    parameter int PARITY_BITS       = ECC_PARITY_W
)(
    input  logic                         ecc_dec_clk,
    input  logic                         ecc_dec_rstn,
    input  logic                         ecc_dec_sw_rst,
    input  logic                         ecc_en,
    input  logic                         rd_valid_i,
    input  logic [ADDR_WIDTH-1:0]        rd_addr_i,
    input  logic [MEMORY_DATA_WIDTH-1:0] encoded_data_i,
    output logic                         rd_valid_o,
    output logic [ADDR_WIDTH-1:0]        rd_addr_o,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         single_err_o,
    output logic                         double_err_o,
    output logic [PARITY_BITS-1:0]       syndrome_o,
    output logic [ADDR_WIDTH-1:0]        err_addr_o,
    input  logic                         cnt_clr_i,
    output logic [15:0]                  sec_cnt_o,
    output logic [15:0]                  ded_cnt_o
);

    logic                         r_s1_valid;
    logic                         r_s1_en;
    logic [ADDR_WIDTH-1:0]        r_s1_addr;
    logic [MEMORY_DATA_WIDTH-1:0] r_s1_cw;
    logic [PARITY_BITS-1:0]       r_s1_syn;
    logic                         r_s1_pe;

    logic [PARITY_BITS-1:0]       w_syn;
    logic                         w_pe;
    logic                         w_syn_ok;
    ecc_status_e                  w_status;
    logic [MEMORY_DATA_WIDTH-1:0] w_flip;
    logic [MEMORY_DATA_WIDTH-1:0] w_fixed;
    logic [DATA_WIDTH-1:0]        w_data;
    logic                         w_flagged;

    syndrome_calculator u_syndrome (
        .i_codeword   (encoded_data_i),
        .o_syndrome   (w_syn),
        .o_parity_err (w_pe)
    );

    // Stage 1: capture the word together with its syndrome and the ecc_en it arrived with.
    always_ff @(posedge ecc_dec_clk or negedge ecc_dec_rstn) begin
        if (!ecc_dec_rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_en    <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_cw    <= '0;
            r_s1_syn   <= '0;
            r_s1_pe    <= 1'b0;
        end else if (ecc_dec_sw_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_en    <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_cw    <= '0;
            r_s1_syn   <= '0;
            r_s1_pe    <= 1'b0;
        end else begin
            r_s1_valid <= rd_valid_i;
            r_s1_en    <= ecc_en;
            r_s1_addr  <= rd_addr_i;
            r_s1_cw    <= encoded_data_i;
            r_s1_syn   <= w_syn;
            r_s1_pe    <= w_pe;
        end
    end

    assign w_syn_ok = r_s1_syn <= PARITY_BITS'(ECC_LAST_POS);

    // An odd error count with a syndrome pointing inside the word is correctable; a zero
    // syndrome with parity mismatch means only the overall parity bit flipped.
    always_comb begin
        w_status = (!r_s1_en || (r_s1_syn == '0 && !r_s1_pe)) ? ECC_CLEAN :
                   (r_s1_pe && w_syn_ok)                      ? ECC_SEC   : ECC_DED;
        w_flip   = (w_status == ECC_SEC && r_s1_syn != '0) ?
                   MEMORY_DATA_WIDTH'(1) << (r_s1_syn - 1'b1) : '0;
        w_fixed  = r_s1_cw ^ w_flip;
    end

    for (genvar d = 0; d < DATA_WIDTH; d++) begin : g_extract
        assign w_data[d] = w_fixed[data_pos(d) - 1];
    end

    // Stage 2: registered outputs; status is masked by valid so idle cycles read as clean.
    always_ff @(posedge ecc_dec_clk or negedge ecc_dec_rstn) begin
        if (!ecc_dec_rstn) begin
            rd_valid_o   <= 1'b0;
            rd_addr_o    <= '0;
            data_out     <= '0;
            single_err_o <= 1'b0;
            double_err_o <= 1'b0;
            syndrome_o   <= '0;
        end else if (ecc_dec_sw_rst) begin
            rd_valid_o   <= 1'b0;
            rd_addr_o    <= '0;
            data_out     <= '0;
            single_err_o <= 1'b0;
            double_err_o <= 1'b0;
            syndrome_o   <= '0;
        end else begin
            rd_valid_o   <= r_s1_valid;
            rd_addr_o    <= r_s1_addr;
            data_out     <= w_data;
            single_err_o <= r_s1_valid && w_status == ECC_SEC;
            double_err_o <= r_s1_valid && w_status == ECC_DED;
            syndrome_o   <= (r_s1_valid && r_s1_en) ? r_s1_syn : '0;
        end
    end

    assign w_flagged = rd_valid_o && (single_err_o || double_err_o);

    // err_addr_o tracks the presented output word; a coincident clear takes priority.
    always_ff @(posedge ecc_dec_clk or negedge ecc_dec_rstn) begin
        if (!ecc_dec_rstn)
            err_addr_o <= '0;
        else if (ecc_dec_sw_rst || cnt_clr_i)
            err_addr_o <= '0;
        else if (w_flagged)
            err_addr_o <= rd_addr_o;
    end

`ifdef ECC_DEC_ERR_CNT_EN
    logic [15:0] r_sec_cnt;
    logic [15:0] r_ded_cnt;

    always_ff @(posedge ecc_dec_clk or negedge ecc_dec_rstn) begin
        if (!ecc_dec_rstn) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else if (ecc_dec_sw_rst || cnt_clr_i) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else begin
            if (rd_valid_o && single_err_o && r_sec_cnt != 16'hFFFF) r_sec_cnt <= r_sec_cnt + 16'd1;
            if (rd_valid_o && double_err_o && r_ded_cnt != 16'hFFFF) r_ded_cnt <= r_ded_cnt + 16'd1;
        end
    end

    assign sec_cnt_o = r_sec_cnt;
    assign ded_cnt_o = r_ded_cnt;
`else
    assign sec_cnt_o = '0;
    assign ded_cnt_o = '0;
`endif

endmodule
